// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Register file plus operand register feeding a combinational ALU.
//            Reads both sources, forwards the in-flight result, registers the
//            operands, and writes the ALU result back one cycle later.
//            A host preload port and a debug peek port give access to the file.
// Revision : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // issue side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_ra1,
  input  logic [ADDR_W-1:0] in_ra2,
  input  logic [ADDR_W-1:0] in_wa,
  input  logic              stall,
  // operands towards the ALU and its result
  output logic [DATA_W-1:0] rs1,
  output logic [DATA_W-1:0] rs2,
  output logic              op_valid,
  input  logic [DATA_W-1:0] alu_rd,
  // writeback happening at the coming edge
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  // host preload
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  // debug peek (raw file contents, never forwarded)
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_wa_q;
  logic              r_op_valid;

  logic              w_wb_valid;
  logic              w_accept;
  logic              w_ld_write;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;

  // A held stage neither accepts nor retires; destination 0 never retires.
  assign in_ready   = !stall;
  assign w_accept   = in_valid && !stall;
  assign w_wb_valid = r_op_valid && !stall && (r_wa_q != '0);
  // The writeback owns the write port when both target the same register.
  assign w_ld_write = ld_en && (ld_addr != '0) &&
                      !(w_wb_valid && (ld_addr == r_wa_q));

  assign rs1      = r_rs1;
  assign rs2      = r_rs2;
  assign op_valid = r_op_valid;
  assign wb_valid = w_wb_valid;
  assign wb_addr  = r_wa_q;
  assign wb_data  = alu_rd;
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  // Source reads: the retiring result bypasses the file; r0 is hardwired zero.
  always_comb begin
    w_src1 = r_regs[in_ra1];
    w_src2 = r_regs[in_ra2];
    if (w_wb_valid && (in_ra1 == r_wa_q)) begin
      w_src1 = alu_rd;
    end else if (in_ra1 == '0) begin
      w_src1 = '0;
    end
    if (w_wb_valid && (in_ra2 == r_wa_q)) begin
      w_src2 = alu_rd;
    end else if (in_ra2 == '0) begin
      w_src2 = '0;
    end
  end

  // Operand register: load on accept, hold under stall, drain when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_wa_q     <= '0;
      r_op_valid <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_rs1      <= w_src1;
        r_rs2      <= w_src2;
        r_wa_q     <= in_wa;
        r_op_valid <= 1'b1;
      end else begin
        r_op_valid <= 1'b0;
      end
    end
  end

  // Register file: writeback and preload may land on different registers together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_ld_write) begin
        r_regs[ld_addr] <= ld_data;
      end
      if (w_wb_valid) begin
        r_regs[r_wa_q] <= alu_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage: directed scenarios and
//            randomized traffic against a behavioural register-file model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, stall, op_valid, wb_valid, ld_en;
  logic [AW-1:0] in_ra1, in_ra2, in_wa, wb_addr, ld_addr, dbg_addr;
  logic [DW-1:0] rs1, rs2, alu_rd, wb_data, ld_data, dbg_data;
  logic [1:0]    alu_sel;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [DW-1:0] m_rf [NR];
  logic [DW-1:0] m_rs1, m_rs2;
  logic [AW-1:0] m_wa;
  logic          m_opv;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_wa(in_wa), .stall(stall),
    .rs1(rs1), .rs2(rs2), .op_valid(op_valid), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // environment ALU
  function automatic logic [DW-1:0] alu_f(input logic [1:0] s, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (s)
      2'd0:    return a | b;
      2'd1:    return a + b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign alu_rd = alu_f(alu_sel, rs1, rs2);

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    m_rs1 = '0; m_rs2 = '0; m_wa = '0; m_opv = 1'b0;
  endtask

  // advance one clock and update the model from the inputs seen at the edge
  task automatic tick();
    logic [DW-1:0] res, r1, r2;
    logic          wbv;
    @(posedge clk);
    if (rst_n) begin
      res = alu_f(alu_sel, m_rs1, m_rs2);
      wbv = m_opv && !stall && (m_wa != 0);
      r1  = (wbv && in_ra1 == m_wa) ? res : m_rf[in_ra1];
      r2  = (wbv && in_ra2 == m_wa) ? res : m_rf[in_ra2];
      if (ld_en && ld_addr != 0) m_rf[ld_addr] = ld_data;
      if (wbv) m_rf[m_wa] = res;
      if (!stall) begin
        if (in_valid) begin
          m_rs1 = r1; m_rs2 = r2; m_wa = in_wa; m_opv = 1'b1;
        end else begin
          m_opv = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; ld_en = 0;
    in_ra1 = 0; in_ra2 = 0; in_wa = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 0; ld_en = 1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] w);
    in_valid = 1; in_ra1 = a1; in_ra2 = a2; in_wa = w;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    alu_sel = 2'd0; idle(); rst_n = 0; m_reset();
    tick(); tick();
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i); #1;
      n_checks++;
      if (dbg_data !== 32'h0) begin
        n_errors++; $display("FAIL reset_dbg[%0d] got %h exp 0", i, dbg_data);
      end
    end
    n_checks++;
    if ({op_valid, wb_valid, rs1, rs2} !== {2'b00, 64'h0}) begin
      n_errors++; $display("FAIL reset_state op_valid=%b wb_valid=%b rs1=%h rs2=%h exp 0", op_valid, wb_valid, rs1, rs2);
    end
    rst_n = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_or_issue();
    alu_sel = 2'd0;
    preload(5'd1, 32'h0000FFFF);
    preload(5'd2, 32'hFFFF0000);
    issue(5'd1, 5'd2, 5'd3);
    #1;
    n_checks++;
    if ({rs1, rs2} !== {32'h0000FFFF, 32'hFFFF0000}) begin
      n_errors++; $display("FAIL or_operands got %h %h exp 0000ffff ffff0000", rs1, rs2);
    end
    n_checks++;
    if ({op_valid, wb_valid, wb_addr} !== {1'b1, 1'b1, 5'd3}) begin
      n_errors++; $display("FAIL or_wb got opv=%b wbv=%b addr=%0d exp 1 1 3", op_valid, wb_valid, wb_addr);
    end
    tick();
    dbg_addr = 5'd3; #1;
    n_checks++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      n_errors++; $display("FAIL or_result_r3 got %h exp ffffffff", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    alu_sel = 2'd0;
    preload(5'd3, 32'h0);
    issue(5'd1, 5'd2, 5'd3);
    issue(5'd3, 5'd0, 5'd4);
    #1;
    n_checks++;
    if ({rs1, rs2} !== {32'hFFFFFFFF, 32'h0}) begin
      n_errors++; $display("FAIL b2b_forward got %h %h exp ffffffff 00000000", rs1, rs2);
    end
    n_checks++;
    if ({wb_valid, wb_addr} !== {1'b1, 5'd4}) begin
      n_errors++; $display("FAIL b2b_wb got wbv=%b addr=%0d exp 1 4", wb_valid, wb_addr);
    end
    tick();
    dbg_addr = 5'd4; #1;
    n_checks++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      n_errors++; $display("FAIL b2b_r4 got %h exp ffffffff", dbg_data);
    end
  endtask

  task automatic test_r0();
    preload(5'd0, 32'h12345678);
    dbg_addr = 5'd0; #1;
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_errors++; $display("FAIL r0_preload got %h exp 0", dbg_data);
    end
    issue(5'd1, 5'd2, 5'd0);
    #1;
    n_checks++;
    if ({op_valid, wb_valid} !== 2'b10) begin
      n_errors++; $display("FAIL r0_issue got opv=%b wbv=%b exp 1 0", op_valid, wb_valid);
    end
    tick();
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_errors++; $display("FAIL r0_after_issue got %h exp 0", dbg_data);
    end
  endtask

  task automatic test_stall();
    int wb_count;
    alu_sel = 2'd1;
    preload(5'd5, 32'h0);
    issue(5'd1, 5'd2, 5'd5);
    stall = 1; in_valid = 1; in_ra1 = 5'd3; in_ra2 = 5'd4; in_wa = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({in_ready, wb_valid, op_valid} !== 3'b001 || rs1 !== 32'h0000FFFF || rs2 !== 32'hFFFF0000) begin
        n_errors++;
        $display("FAIL stall_hold[%0d] got rdy=%b wbv=%b opv=%b rs1=%h rs2=%h exp 0 0 1 0000ffff ffff0000",
                 i, in_ready, wb_valid, op_valid, rs1, rs2);
      end
      tick();
    end
    dbg_addr = 5'd5; #1;
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_errors++; $display("FAIL stall_no_write got %h exp 0", dbg_data);
    end
    stall = 0; in_valid = 0;
    wb_count = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (wb_valid === 1'b1) wb_count++;
      tick();
    end
    n_checks++;
    if (wb_count != 1) begin
      n_errors++; $display("FAIL stall_release_wb_count got %0d exp 1", wb_count);
    end
    n_checks++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      n_errors++; $display("FAIL stall_release_r5 got %h exp ffffffff", dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    alu_sel = 2'd0;
    preload(5'd7, 32'h0);
    issue(5'd1, 5'd2, 5'd7);
    #1;
    rst_n = 0;
    #1;
    n_checks++;
    if ({op_valid, wb_valid, rs1} !== {2'b00, 32'h0}) begin
      n_errors++; $display("FAIL async_reset got opv=%b wbv=%b rs1=%h exp 0 0 0", op_valid, wb_valid, rs1);
    end
    m_reset();
    tick();
    rst_n = 1;
    dbg_addr = 5'd7; #1;
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_errors++; $display("FAIL async_reset_r7 got %h exp 0", dbg_data);
    end
    issue(5'd0, 5'd0, 5'd9);
    #1;
    n_checks++;
    if (op_valid !== 1'b1) begin
      n_errors++; $display("FAIL first_accept got %b exp 1", op_valid);
    end
  endtask

  task automatic test_ld_collision();
    alu_sel = 2'd0;
    preload(5'd1, 32'h0000FFFF);
    preload(5'd2, 32'hFFFF0000);
    issue(5'd1, 5'd2, 5'd8);
    ld_en = 1; ld_addr = 5'd8; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 0;
    dbg_addr = 5'd8; #1;
    n_checks++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      n_errors++; $display("FAIL ld_wb_collision got %h exp ffffffff", dbg_data);
    end
    issue(5'd1, 5'd2, 5'd10);
    ld_en = 1; ld_addr = 5'd11; ld_data = 32'h13579BDF;
    tick();
    ld_en = 0;
    dbg_addr = 5'd10; #1;
    n_checks++;
    if (dbg_data !== 32'hFFFFFFFF) begin
      n_errors++; $display("FAIL ld_parallel_wb got %h exp ffffffff", dbg_data);
    end
    dbg_addr = 5'd11; #1;
    n_checks++;
    if (dbg_data !== 32'h13579BDF) begin
      n_errors++; $display("FAIL ld_parallel_ld got %h exp 13579bdf", dbg_data);
    end
  endtask

  task automatic test_random();
    logic          e_wbv;
    logic [DW-1:0] e_res;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      stall    = ($urandom % 4) == 0;
      ld_en    = ($urandom % 3) == 0;
      in_ra1   = AW'($urandom_range(0, 7));
      in_ra2   = AW'($urandom_range(0, 7));
      in_wa    = AW'($urandom_range(0, 7));
      ld_addr  = AW'($urandom_range(0, 7));
      ld_data  = $urandom;
      alu_sel  = 2'($urandom);
      dbg_addr = AW'($urandom_range(0, NR - 1));
      #1;
      e_wbv = m_opv && !stall && (m_wa != 0);
      e_res = alu_f(alu_sel, m_rs1, m_rs2);
      n_checks++;
      if ({in_ready, op_valid, wb_valid} !== {!stall, m_opv, e_wbv}) begin
        n_errors++; $display("FAIL rnd_ctrl[%0d] got rdy/opv/wbv=%b%b%b exp %b%b%b",
                             c, in_ready, op_valid, wb_valid, !stall, m_opv, e_wbv);
      end
      n_checks++;
      if (rs1 !== m_rs1 || rs2 !== m_rs2) begin
        n_errors++; $display("FAIL rnd_operands[%0d] got %h %h exp %h %h", c, rs1, rs2, m_rs1, m_rs2);
      end
      if (e_wbv) begin
        n_checks++;
        if (wb_addr !== m_wa || wb_data !== e_res) begin
          n_errors++; $display("FAIL rnd_wb[%0d] got %0d:%h exp %0d:%h", c, wb_addr, wb_data, m_wa, e_res);
        end
      end
      n_checks++;
      if (dbg_data !== m_rf[dbg_addr]) begin
        n_errors++; $display("FAIL rnd_dbg[%0d] r%0d got %h exp %h", c, dbg_addr, dbg_data, m_rf[dbg_addr]);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_or_issue();
    test_back_to_back();
    test_r0();
    test_stall();
    test_reset_mid();
    test_ld_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
